endian_swap_arbiter: RTL
========================

# endian_swap_arbiter

Shares one 32-bit byte-swap datapath between two requesters. Each request carries a data word and a swap mode; a round-robin arbiter grants one requester per cycle, the word is converted and captured in a one-deep output register behind a valid/ready handshake. The block sits between the bus-side requesters (DMA and CPU write paths) and the downstream little/big-endian consumer, and keeps per-requester completion counters for status readback.

## Interface
- DATA_W, 32, word width; only 32 supported
- BYTE, 8, byte width
- CNT_W, 16, width of each completion counter
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid_i  input  2  per-requester request valid (bit i = requester i)
- req_ready_o  output  2  per-requester accept; transfer on valid&ready
- req_data0_i  input  DATA_W  requester 0 word
- req_data1_i  input  DATA_W  requester 1 word
- req_mode0_i  input  2  requester 0 mode
- req_mode1_i  input  2  requester 1 mode
- out_valid_o  output  1  output register holds a word
- out_ready_i  input  1  downstream accept
- out_data_o  output  DATA_W  converted word
- out_src_o  output  1  requester index of out_data_o
- done_cnt0_o  output  CNT_W  words from requester 0 accepted downstream
- done_cnt1_o  output  CNT_W  words from requester 1 accepted downstream
- mode_err_o  output  1  sticky: a reserved mode was accepted

## Operation
- Modes: 00 PASS (unchanged); 01 SWAP32 (byte 0↔3, 1↔2); 10 SWAP16 (swap bytes within each 16-bit half); 11 reserved: converted as PASS, sets mode_err_o.
- Arbiter state: last_grant (1 bit). Reset value 1, so requester 0 wins the first tie.
- Grant: if both valid, grant the requester != last_grant; if one valid, grant it; if none, no grant.
- Slot free = !out_valid_o || out_ready_i.
- req_ready_o[i] = grant[i] && slot free; at most one bit set. req_ready_o depends combinationally on req_valid_i and out_ready_i.
- On accept: out_data_o <= converted word, out_src_o <= i, out_valid_o <= 1, last_grant <= i. last_grant changes only on an accepted transfer.
- On downstream handshake (out_valid_o && out_ready_i) with no new accept: out_valid_o <= 0. Accept and drain in the same cycle: register reloads, out_valid_o stays 1.
- Output holds stable while out_valid_o && !out_ready_i.
- done_cntN increments on downstream handshake when out_src_o == N; wraps from 2^CNT_W-1 to 0.
- mode_err_o sets on accepting mode 11; cleared only by reset.
- Reset: out_valid_o=0, out_data_o=0, out_src_o=0, counters=0, mode_err_o=0, last_grant=1. Reset has priority over any handshake; an in-flight output word is discarded and not counted.

## Timing
- Latency: request accept in cycle N → out_valid_o with data in cycle N+1.
- Throughput: one word per cycle when out_ready_i held high.
- Both requesters continuously valid, out_ready_i=1: grants alternate 0,1,0,1…
- Counter update visible the cycle after the downstream handshake.
- No combinational path from req_data*_i to out_data_o.

## Structure
- Package endian_swap_pkg: swap_mode_e enum (MODE_PASS, MODE_SWAP32, MODE_SWAP16, MODE_RSVD), DATA_W/BYTE constants.
- Sub-module byte_swap_unit: combinational, data + mode in, converted word + reserved flag out; instantiated once after the grant mux.
- Top holds arbiter, output register, counters, sticky flag.

## Test plan
- Requester 0 only, mode SWAP32, data 0x11223344, out_ready_i=1 → out_data_o=0x44332211, out_src_o=0 one cycle later; done_cnt0_o=1.
- Requester 1 only, SWAP16, 0x11223344 → 0x22114433; PASS → 0x11223344; mode 11 → 0x11223344 and mode_err_o=1 until reset.
- Both valid for 4 cycles after reset, out_ready_i=1 → out_src_o sequence 0,1,0,1; each counter = 2.
- out_ready_i=0 with word held → out_data_o stable, req_ready_o=00; raise out_ready_i with requester 0 valid → drain and reload same cycle, out_valid_o stays 1.
- Preload done_cnt0 to 0xFFFF via 65535 transfers, one more → 0x0000.
- Assert reset while out_valid_o=1 and out_ready_i=0 → next cycle all outputs zero, counters unchanged at 0, requester 0 wins next tie.

Source files
------------

// File: rtl/endian_swap_pkg.sv
// Shared constants and swap-mode encoding for the endian swap arbiter.
package endian_swap_pkg;

  localparam int DATA_W = 32;
  localparam int BYTE   = 8;
  localparam int NBYTES = DATA_W / BYTE;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_SWAP32 = 2'b01,
    MODE_SWAP16 = 2'b10,
    MODE_RSVD   = 2'b11
  } swap_mode_e;

endpackage

// File: rtl/byte_swap_unit.sv
// Combinational byte reorder of one word; the reserved mode passes data through and is flagged.
module byte_swap_unit
  import endian_swap_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  swap_mode_e        mode,
  output logic [DATA_W-1:0] dout,
  output logic              rsvd
);

  logic [DATA_W-1:0] swap32;
  logic [DATA_W-1:0] swap16;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign swap32[gi*BYTE +: BYTE] = din[(NBYTES-1-gi)*BYTE +: BYTE];
      assign swap16[gi*BYTE +: BYTE] = din[(gi ^ 1)*BYTE +: BYTE];
    end
  endgenerate

  always_comb begin
    dout = din;
    rsvd = 1'b0;
    case (mode)
      MODE_SWAP32: dout = swap32;
      MODE_SWAP16: dout = swap16;
      MODE_RSVD:   rsvd = 1'b1;
      default:     dout = din;
    endcase
  end

endmodule

// File: rtl/endian_swap_arbiter.sv
// Two-requester round-robin front end sharing one byte-swap datapath, with a
// one-deep registered output stage, per-requester completion counters and a sticky mode error.
module endian_swap_arbiter
  import endian_swap_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [DATA_W-1:0] req_data0_i,
  input  logic [DATA_W-1:0] req_data1_i,
  input  logic [1:0]        req_mode0_i,
  input  logic [1:0]        req_mode1_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_src_o,
  output logic [CNT_W-1:0]  done_cnt0_o,
  output logic [CNT_W-1:0]  done_cnt1_o,
  output logic              mode_err_o
);

  logic              last_grant_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_src_reg;
  logic [CNT_W-1:0]  cnt0_reg;
  logic [CNT_W-1:0]  cnt1_reg;
  logic              mode_err_reg;

  logic [1:0]        grant;
  logic              slot_free;
  logic              accept;
  logic              drain;
  logic              sel;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_mode;
  logic [DATA_W-1:0] conv_data;
  logic              conv_rsvd;

  // On a tie the requester that did not win the last accepted transfer goes next.
  always_comb begin
    grant = 2'b00;
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign slot_free   = !out_valid_reg || out_ready_i;
  assign req_ready_o = grant & {2{slot_free}};
  assign accept      = |req_ready_o;
  assign drain       = out_valid_reg && out_ready_i;
  assign sel         = req_ready_o[1];
  assign sel_data    = sel ? req_data1_i : req_data0_i;
  assign sel_mode    = sel ? req_mode1_i : req_mode0_i;

  byte_swap_unit u_swap (
    .din  (sel_data),
    .mode (swap_mode_e'(sel_mode)),
    .dout (conv_data),
    .rsvd (conv_rsvd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_src_reg    <= 1'b0;
      cnt0_reg       <= '0;
      cnt1_reg       <= '0;
      mode_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= conv_data;
        out_src_reg    <= sel;
        last_grant_reg <= sel;
        if (conv_rsvd) mode_err_reg <= 1'b1;
      end else if (drain) begin
        out_valid_reg <= 1'b0;
      end
      // Counts reflect the word leaving the register, not the one being loaded.
      if (drain) begin
        if (out_src_reg) cnt1_reg <= cnt1_reg + 1'b1;
        else             cnt0_reg <= cnt0_reg + 1'b1;
      end
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_src_o   = out_src_reg;
  assign done_cnt0_o = cnt0_reg;
  assign done_cnt1_o = cnt1_reg;
  assign mode_err_o  = mode_err_reg;

endmodule
